// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: req/ack memory reader feeding a FWFT instruction queue with redirect flush.
// Optional FETCH_STATS_EN adds saturating fetched/flushed counters (ports tied to 0 otherwise).
module inst_fetch_queue #(
  parameter int          INST_W   = 16,
  parameter int          ADDR_W   = 12,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic [INST_W-1:0] ins_o,
  output logic [ADDR_W-1:0] ins_pc_o,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [15:0]       stat_fetched_o,
  output logic [15:0]       stat_flushed_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [INST_W-1:0] head_data_q, head_data_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              head_valid_q, head_valid_d;

  logic [INST_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic             pop;
  logic             push;
  logic [PTR_W-1:0] rd_next;

  assign pop     = head_valid_q & ins_ready_i;
  assign push    = (state_q == S_WAIT) & mem_ack_i & ~redirect_i;
  assign rd_next = rd_ptr_q + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= ADDR_W'(RESET_PC);
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_data_q  <= '0;
      head_pc_q    <= '0;
      head_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_data_q  <= head_data_d;
      head_pc_q    <= head_pc_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata_i;
      pc_mem[wr_ptr_q]   <= mem_addr_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_data_d  = head_data_q;
    head_pc_d    = head_pc_q;
    head_valid_d = head_valid_q;

    if (redirect_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
      fetch_pc_d   = redirect_pc_i;
      unique case (state_q)
        S_FETCH: begin
          state_d   = S_FETCH;
          mem_req_d = 1'b0;
        end
        S_WAIT, S_DRAIN: begin
          // An outstanding read must still complete before a new one is issued.
          if (mem_ack_i) begin
            state_d   = S_FETCH;
            mem_req_d = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d   = S_FETCH;
          mem_req_d = 1'b0;
        end
      endcase
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_next;

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      // Head register lags storage by one edge, so a freshly pushed word is never bypassed.
      if (pop) begin
        if (count_q > CNT_ONE) begin
          head_data_d  = data_mem[rd_next];
          head_pc_d    = pc_mem[rd_next];
          head_valid_d = 1'b1;
        end else begin
          head_valid_d = 1'b0;
        end
      end else if (!head_valid_q && (count_q != '0)) begin
        head_data_d  = data_mem[rd_ptr_q];
        head_pc_d    = pc_mem[rd_ptr_q];
        head_valid_d = 1'b1;
      end

      unique case (state_q)
        S_FETCH: begin
          if (count_q < CNT_FULL) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            mem_req_d  = 1'b0;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (mem_ack_i) begin
            mem_req_d = 1'b0;
            state_d   = S_FETCH;
          end
        end
        default: begin
          mem_req_d = 1'b0;
          state_d   = S_FETCH;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign ins_o       = head_data_q;
  assign ins_pc_o    = head_pc_q;
  assign ins_valid_o = head_valid_q;

`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched_q;
  logic [15:0] stat_flushed_q;
  logic [15:0] flush_amt;
  logic [16:0] flush_sum;

  // A redirect while a read is outstanding always throws that word away, so it counts once here.
  assign flush_amt = 16'(count_q) + 16'(state_q == S_WAIT);
  assign flush_sum = {1'b0, stat_flushed_q} + {1'b0, flush_amt};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (pop && !redirect_i && (stat_fetched_q != 16'hFFFF))
        stat_fetched_q <= stat_fetched_q + 16'd1;
      if (redirect_i)
        stat_flushed_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  assign stat_fetched_o = stat_fetched_q;
  assign stat_flushed_o = stat_flushed_q;
`else
  assign stat_fetched_o = 16'h0000;
  assign stat_flushed_o = 16'h0000;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue; a second instance with RESET_PC=12'hFFE covers PC wrap.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ins;
  logic [11:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic [15:0] stat_fetched;
  logic [15:0] stat_flushed;

  logic        w_mem_req;
  logic [11:0] w_mem_addr;
  logic        w_mem_ack;
  logic [15:0] w_mem_rdata;
  logic [15:0] w_ins;
  logic [11:0] w_ins_pc;
  logic        w_ins_valid;
  logic        w_ins_ready;
  logic        w_redirect;
  logic [11:0] w_redirect_pc;
  logic [15:0] w_stat_fetched;
  logic [15:0] w_stat_flushed;

  logic        resp_en;
  int          ack_delay;
  int          total;
  int          bad;

  inst_fetch_queue dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_ack_i      (mem_ack),
    .mem_rdata_i    (mem_rdata),
    .ins_o          (ins),
    .ins_pc_o       (ins_pc),
    .ins_valid_o    (ins_valid),
    .ins_ready_i    (ins_ready),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .stat_fetched_o (stat_fetched),
    .stat_flushed_o (stat_flushed)
  );

  inst_fetch_queue #(.RESET_PC(12'hFFE)) dut_wrap (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_req_o      (w_mem_req),
    .mem_addr_o     (w_mem_addr),
    .mem_ack_i      (w_mem_ack),
    .mem_rdata_i    (w_mem_rdata),
    .ins_o          (w_ins),
    .ins_pc_o       (w_ins_pc),
    .ins_valid_o    (w_ins_valid),
    .ins_ready_i    (w_ins_ready),
    .redirect_i     (w_redirect),
    .redirect_pc_i  (w_redirect_pc),
    .stat_fetched_o (w_stat_fetched),
    .stat_flushed_o (w_stat_flushed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for the main instance: data = 16'h1000 + addr, ack after ack_delay idle cycles.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_en) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'h1000 + {4'h0, mem_addr};
            wait_cnt  = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin : responder_wrap
    w_mem_ack   = 1'b0;
    w_mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #2;
      w_mem_ack = 1'b0;
      if (w_mem_req) begin
        w_mem_ack   = 1'b1;
        w_mem_rdata = 16'h1000 + {4'h0, w_mem_addr};
      end
    end
  end

  task automatic apply_reset;
    rst       = 1'b0;
    resp_en   = 1'b0;
    redirect  = 1'b0;
    ins_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ins_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_word(input logic [15:0] d);
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = d;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req got=%b want=0", mem_req); end
    total++; if (mem_addr !== 12'h000) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h want=000", mem_addr); end
    total++; if (ins_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_ins_valid got=%b want=0", ins_valid); end
    total++; if (ins !== 16'h0000) begin bad++; $display("[TB] FAIL reset_ins got=%h want=0000", ins); end
    total++; if (ins_pc !== 12'h000) begin bad++; $display("[TB] FAIL reset_ins_pc got=%h want=000", ins_pc); end
  endtask

  task automatic test_stream;
    int          got;
    logic [11:0] exp_pc;
    apply_reset();
    resp_en   = 1'b1;
    ack_delay = 0;
    ins_ready = 1'b1;
    rst       = 1'b1;
    got       = 0;
    exp_pc    = 12'h000;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      if (ins_valid) begin
        total++;
        if (ins !== 16'h1000 + {4'h0, exp_pc} || ins_pc !== exp_pc) begin
          bad++;
          $display("[TB] FAIL stream_word%0d got ins=%h pc=%h want ins=%h pc=%h",
                   got, ins, ins_pc, 16'h1000 + {4'h0, exp_pc}, exp_pc);
        end
        got++;
        exp_pc = exp_pc + 12'd1;
      end
    end
    total++; if (got != 8) begin bad++; $display("[TB] FAIL stream_count got=%0d want=8", got); end
  endtask

  task automatic test_latency;
    bit found;
    apply_reset();
    rst = 1'b1;
    wait_req(found);
    total++; if (!found || mem_addr !== 12'h000) begin bad++; $display("[TB] FAIL lat_req got found=%b addr=%h want 1/000", found, mem_addr); end
    ack_word(16'hABCD);
    @(negedge clk);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_no_bypass got=%b want=0", ins_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL lat_req_drop got=%b want=0", mem_req); end
    @(negedge clk);
    total++;
    if (ins_valid !== 1'b1 || ins !== 16'hABCD || ins_pc !== 12'h000) begin
      bad++;
      $display("[TB] FAIL lat_head got v=%b ins=%h pc=%h want 1/abcd/000", ins_valid, ins, ins_pc);
    end
  endtask

  task automatic test_backpressure;
    int          acks;
    int          got;
    logic [11:0] exp_pc;
    apply_reset();
    resp_en   = 1'b1;
    ack_delay = 0;
    rst       = 1'b1;
    acks      = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_ack) acks++;
    end
    total++; if (acks != 4) begin bad++; $display("[TB] FAIL bp_acks got=%0d want=4", acks); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_idle got=%b want=0", mem_req); end
    total++;
    if (ins_valid !== 1'b1 || ins !== 16'h1000 || ins_pc !== 12'h000) begin
      bad++;
      $display("[TB] FAIL bp_head got v=%b ins=%h pc=%h want 1/1000/000", ins_valid, ins, ins_pc);
    end
    @(posedge clk);
    #1;
    ins_ready = 1'b1;
    got    = 0;
    exp_pc = 12'h000;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      if (ins_valid) begin
        total++;
        if (ins !== 16'h1000 + {4'h0, exp_pc} || ins_pc !== exp_pc) begin
          bad++;
          $display("[TB] FAIL bp_word%0d got ins=%h pc=%h want ins=%h pc=%h",
                   got, ins, ins_pc, 16'h1000 + {4'h0, exp_pc}, exp_pc);
        end
        got++;
        exp_pc = exp_pc + 12'd1;
      end
    end
    total++; if (got != 5) begin bad++; $display("[TB] FAIL bp_count got=%0d want=5", got); end
  endtask

  task automatic test_redirect_wait;
    bit found;
    apply_reset();
    ins_ready = 1'b1;
    rst       = 1'b1;
    wait_req(found);
    total++; if (!found || mem_addr !== 12'h000) begin bad++; $display("[TB] FAIL rw_first_req got found=%b addr=%h want 1/000", found, mem_addr); end
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 12'h080;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000 || ins_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rw_drain_hold got req=%b addr=%h v=%b want 1/000/0", mem_req, mem_addr, ins_valid);
    end
    ack_word(16'hDEAD);
    @(negedge clk);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_old_discard got v=%b ins=%h want v=0", ins_valid, ins); end
    wait_req(found);
    total++; if (!found || mem_addr !== 12'h080) begin bad++; $display("[TB] FAIL rw_new_addr got found=%b addr=%h want 1/080", found, mem_addr); end
    ack_word(16'h1080);
    wait_valid(found);
    total++;
    if (!found || ins !== 16'h1080 || ins_pc !== 12'h080) begin
      bad++;
      $display("[TB] FAIL rw_first_ins got found=%b ins=%h pc=%h want 1/1080/080", found, ins, ins_pc);
    end
  endtask

  task automatic test_redirect_ack_pop;
    bit found;
    apply_reset();
    rst = 1'b1;
    wait_req(found);
    ack_word(16'h1000);
    wait_req(found);
    ack_word(16'h1001);
    wait_req(found);
    total++;
    if (!found || mem_addr !== 12'h002 || ins_valid !== 1'b1 || ins !== 16'h1000) begin
      bad++;
      $display("[TB] FAIL rap_setup got found=%b addr=%h v=%b ins=%h want 1/002/1/1000", found, mem_addr, ins_valid, ins);
    end
    @(posedge clk);
    #1;
    mem_ack     = 1'b1;
    mem_rdata   = 16'h1002;
    ins_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 12'h200;
    @(posedge clk);
    #1;
    mem_ack  = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("[TB] FAIL rap_flush got v=%b ins=%h want v=0", ins_valid, ins); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rap_req_drop got=%b want=0", mem_req); end
    wait_req(found);
    total++;
    if (!found || mem_addr !== 12'h200 || ins_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rap_new_req got found=%b addr=%h v=%b want 1/200/0", found, mem_addr, ins_valid);
    end
    ack_word(16'h1200);
    wait_valid(found);
    total++;
    if (!found || ins !== 16'h1200 || ins_pc !== 12'h200) begin
      bad++;
      $display("[TB] FAIL rap_first_ins got found=%b ins=%h pc=%h want 1/1200/200", found, ins, ins_pc);
    end
  endtask

  task automatic test_pc_wrap;
    int          got;
    logic [11:0] exp_pc;
    apply_reset();
    rst    = 1'b1;
    got    = 0;
    exp_pc = 12'hFFE;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (w_ins_valid) begin
        total++;
        if (w_ins_pc !== exp_pc || w_ins !== 16'h1000 + {4'h0, exp_pc}) begin
          bad++;
          $display("[TB] FAIL wrap_word%0d got ins=%h pc=%h want ins=%h pc=%h",
                   got, w_ins, w_ins_pc, 16'h1000 + {4'h0, exp_pc}, exp_pc);
        end
        got++;
        exp_pc = exp_pc + 12'd1;
      end
    end
    total++; if (got != 4) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=4", got); end
  endtask

  task automatic test_mid_reset;
    bit found;
    apply_reset();
    ins_ready = 1'b1;
    rst       = 1'b1;
    wait_req(found);
    total++; if (!found) begin bad++; $display("[TB] FAIL mr_req got found=0 want 1"); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ins_valid !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mr_after_reset got v=%b req=%b want 0/0", ins_valid, mem_req);
    end
`ifdef FETCH_STATS_EN
    total++;
    if (stat_fetched !== 16'h0 || stat_flushed !== 16'h0) begin
      bad++;
      $display("[TB] FAIL mr_stats got fetched=%h flushed=%h want 0/0", stat_fetched, stat_flushed);
    end
`else
    total++;
    if (stat_fetched !== 16'h0 || stat_flushed !== 16'h0 || w_stat_fetched !== 16'h0 || w_stat_flushed !== 16'h0) begin
      bad++;
      $display("[TB] FAIL mr_stats_tied got fetched=%h flushed=%h want 0/0", stat_fetched, stat_flushed);
    end
`endif
    wait_req(found);
    total++;
    if (!found || mem_addr !== 12'h000 || ins_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mr_fresh_req got found=%b addr=%h v=%b want 1/000/0", found, mem_addr, ins_valid);
    end
    ack_word(16'h1000);
    wait_valid(found);
    total++;
    if (!found || ins !== 16'h1000 || ins_pc !== 12'h000) begin
      bad++;
      $display("[TB] FAIL mr_first_ins got found=%b ins=%h pc=%h want 1/1000/000", found, ins, ins_pc);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    resp_en       = 1'b0;
    ack_delay     = 0;
    mem_ack       = 1'b0;
    mem_rdata     = 16'h0;
    ins_ready     = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 12'h000;
    w_ins_ready   = 1'b1;
    w_redirect    = 1'b0;
    w_redirect_pc = 12'h000;

    test_reset();
    test_stream();
    test_latency();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_mid_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
